// File: rtl/iq_mixer_pipelined.sv
// I/Q down-conversion mixer with a fixed 3-stage pipeline: 1-bit LO sign flip or rounded multi-bit multiply.
// Build option: define MIXER_NEG_SAT_EN to saturate mode-0 negation of the most negative LO sample.
module iq_mixer_pipelined #(
   parameter int unsigned LO_WIDTH  = 12,
   parameter int unsigned RF_WIDTH  = 8,
   parameter int unsigned RF_DELAY  = 2,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mode,
   input  logic                 rf_bit,
   input  logic [RF_WIDTH-1:0]  rf_sample,
   input  logic [LO_WIDTH-1:0]  sinewave_in,
   input  logic [LO_WIDTH-1:0]  cosinewave_in,
   input  logic                 in_valid,
   output logic                 rf_out,
   output logic [LO_WIDTH-1:0]  sinewave_out,
   output logic [LO_WIDTH-1:0]  cosinewave_out,
   output logic                 out_valid,
   output logic [CNT_WIDTH-1:0] sat_count,
   input  logic                 sat_clear
);
   localparam int unsigned PW = RF_WIDTH + LO_WIDTH;
   localparam logic signed [PW:0] RND  = (PW+1)'(2 ** (RF_WIDTH - 2));
   localparam logic signed [PW:0] MAXV = (PW+1)'(2 ** (LO_WIDTH - 1) - 1);
   localparam logic signed [PW:0] MINV = ~MAXV;

   logic                       rf_bit_dly;
   logic signed [RF_WIDTH-1:0] rf_samp_dly;

   generate
      if (RF_DELAY == 0) begin : g_no_dly
         assign rf_bit_dly  = rf_bit;
         assign rf_samp_dly = rf_sample;
      end else begin : g_dly
         logic [RF_DELAY-1:0] bit_line_q, bit_line_d;
         logic [RF_WIDTH-1:0] samp_line_q [RF_DELAY];
         logic [RF_WIDTH-1:0] samp_line_d [RF_DELAY];

         always_comb begin
            bit_line_d     = bit_line_q;
            samp_line_d    = samp_line_q;
            bit_line_d[0]  = rf_bit;
            samp_line_d[0] = rf_sample;
            for (int unsigned i = 1; i < RF_DELAY; i++) begin
               bit_line_d[i]  = bit_line_q[i-1];
               samp_line_d[i] = samp_line_q[i-1];
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               bit_line_q  <= '1;
               samp_line_q <= '{default: '0};
            end else begin
               bit_line_q  <= bit_line_d;
               samp_line_q <= samp_line_d;
            end
         end

         assign rf_bit_dly  = bit_line_q[RF_DELAY-1];
         assign rf_samp_dly = samp_line_q[RF_DELAY-1];
      end
   endgenerate

   // Returns {clipped, value}; mode 1 rounds half-up before the arithmetic shift.
   function automatic logic [LO_WIDTH:0] shape(input logic signed [PW-1:0] prod, input logic m);
      logic signed [PW:0] v;
      logic               clip_en;
      v = {prod[PW-1], prod};
      if (m) v = (v + RND) >>> (RF_WIDTH - 1);
`ifdef MIXER_NEG_SAT_EN
      clip_en = 1'b1;
`else
      clip_en = m;
`endif
      if (clip_en && (v > MAXV)) return {1'b1, MAXV[LO_WIDTH-1:0]};
      if (clip_en && (v < MINV)) return {1'b1, MINV[LO_WIDTH-1:0]};
      return {1'b0, v[LO_WIDTH-1:0]};
   endfunction

   logic                       rf_out_q, rf_out_d;
   logic signed [LO_WIDTH-1:0] sin_s1_q, sin_s1_d, cos_s1_q, cos_s1_d;
   logic signed [RF_WIDTH-1:0] rf_samp_s1_q, rf_samp_s1_d;
   logic                       rf_bit_s1_q, rf_bit_s1_d, mode_s1_q, mode_s1_d, vld_s1_q, vld_s1_d;
   logic signed [PW-1:0]       prod_sin_s2_q, prod_sin_s2_d, prod_cos_s2_q, prod_cos_s2_d;
   logic                       mode_s2_q, mode_s2_d, vld_s2_q, vld_s2_d;
   logic [LO_WIDTH-1:0]        sin_out_q, sin_out_d, cos_out_q, cos_out_d;
   logic                       vld_out_q, vld_out_d;
   logic [CNT_WIDTH-1:0]       sat_cnt_q, sat_cnt_d;
   logic signed [PW-1:0]       rf_ext, sin_ext, cos_ext;
   logic [LO_WIDTH:0]          sin_shaped, cos_shaped;

   always_comb begin
      rf_out_d     = rf_bit;
      sin_s1_d     = sinewave_in;
      cos_s1_d     = cosinewave_in;
      rf_samp_s1_d = rf_samp_dly;
      rf_bit_s1_d  = rf_bit_dly;
      mode_s1_d    = mode;
      vld_s1_d     = in_valid;

      rf_ext  = rf_samp_s1_q;
      sin_ext = sin_s1_q;
      cos_ext = cos_s1_q;
      if (mode_s1_q) begin
         prod_sin_s2_d = rf_ext * sin_ext;
         prod_cos_s2_d = rf_ext * cos_ext;
      end else if (rf_bit_s1_q) begin
         prod_sin_s2_d = -sin_ext;
         prod_cos_s2_d = -cos_ext;
      end else begin
         prod_sin_s2_d = sin_ext;
         prod_cos_s2_d = cos_ext;
      end
      mode_s2_d = mode_s1_q;
      vld_s2_d  = vld_s1_q;

      sin_shaped = shape(prod_sin_s2_q, mode_s2_q);
      cos_shaped = shape(prod_cos_s2_q, mode_s2_q);
      vld_out_d  = vld_s2_q;
      sin_out_d  = sin_out_q;
      cos_out_d  = cos_out_q;
      if (vld_s2_q) begin
         sin_out_d = sin_shaped[LO_WIDTH-1:0];
         cos_out_d = cos_shaped[LO_WIDTH-1:0];
      end

      sat_cnt_d = sat_cnt_q;
      if (sat_clear) begin
         sat_cnt_d = '0;
      end else if (vld_s2_q && (sin_shaped[LO_WIDTH] || cos_shaped[LO_WIDTH]) && (sat_cnt_q != '1)) begin
         sat_cnt_d = sat_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_out_q      <= 1'b1;
         sin_s1_q      <= '0;
         cos_s1_q      <= '0;
         rf_samp_s1_q  <= '0;
         rf_bit_s1_q   <= 1'b0;
         mode_s1_q     <= 1'b0;
         vld_s1_q      <= 1'b0;
         prod_sin_s2_q <= '0;
         prod_cos_s2_q <= '0;
         mode_s2_q     <= 1'b0;
         vld_s2_q      <= 1'b0;
         sin_out_q     <= '0;
         cos_out_q     <= '0;
         vld_out_q     <= 1'b0;
         sat_cnt_q     <= '0;
      end else begin
         rf_out_q      <= rf_out_d;
         sin_s1_q      <= sin_s1_d;
         cos_s1_q      <= cos_s1_d;
         rf_samp_s1_q  <= rf_samp_s1_d;
         rf_bit_s1_q   <= rf_bit_s1_d;
         mode_s1_q     <= mode_s1_d;
         vld_s1_q      <= vld_s1_d;
         prod_sin_s2_q <= prod_sin_s2_d;
         prod_cos_s2_q <= prod_cos_s2_d;
         mode_s2_q     <= mode_s2_d;
         vld_s2_q      <= vld_s2_d;
         sin_out_q     <= sin_out_d;
         cos_out_q     <= cos_out_d;
         vld_out_q     <= vld_out_d;
         sat_cnt_q     <= sat_cnt_d;
      end
   end

   assign rf_out         = rf_out_q;
   assign sinewave_out   = sin_out_q;
   assign cosinewave_out = cos_out_q;
   assign out_valid      = vld_out_q;
   assign sat_count      = sat_cnt_q;

endmodule

// File: doc/iq_mixer_pipelined.md
Name: iq_mixer_pipelined

Overview:
- Parametrised I/Q down-conversion mixer: multiplies an RF stream by NCO sine/cosine (LO) samples and produces I/Q outputs for the CIC decimator chain.
- Two runtime modes:
  - 1-bit mode: sigma-delta comparator bit drives a sign flip of the LO.
  - Multi-bit mode: signed RF sample is multiplied by the LO, with rounding.
- Adds a programmable RF alignment delay, valid tagging, fixed 3-cycle latency and a saturation-event counter.

Parameters:
- LO_WIDTH, 12, width of signed sine/cosine inputs and of the I/Q outputs.
- RF_WIDTH, 8, width of signed multi-bit RF sample (2..16).
- RF_DELAY, 2, RF delay-line depth in clocks before mixing (0..15); aligns RF with NCO latency.
- CNT_WIDTH, 16, width of saturation-event counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- mode  in  1  0 = 1-bit sign-flip mode, 1 = multi-bit multiply mode
- rf_bit  in  1  comparator bit (mode 0)
- rf_sample  in  RF_WIDTH  signed RF sample (mode 1)
- sinewave_in  in  LO_WIDTH  signed NCO sine
- cosinewave_in  in  LO_WIDTH  signed NCO cosine
- in_valid  in  1  LO samples valid this cycle
- rf_out  out  1  rf_bit registered one clock (feedback to comparator DAC)
- sinewave_out  out  LO_WIDTH  signed mixed sine (Q)
- cosinewave_out  out  LO_WIDTH  signed mixed cosine (I)
- out_valid  out  1  qualifies outputs
- sat_count  out  CNT_WIDTH  number of saturated output samples
- sat_clear  in  1  synchronous clear of sat_count

Behaviour:
- Reset (async assert, sync release): rf_out=1, RF bit delay line all 1, RF sample delay line all 0, all pipeline registers 0, sinewave_out=cosinewave_out=0, out_valid=0, sat_count=0.
- RF delay line:
  - Shifts every clock, independent of in_valid.
  - RF_DELAY=0 means the RF inputs feed stage 1 directly.
- Pipeline: fixed latency 3 clocks from in_valid to out_valid, identical in both modes.
  - Stage 1: register LO samples, delayed RF, mode and in_valid.
  - Stage 2: form products.
  - Stage 3: round, saturate, register outputs.
- No backpressure: out_valid is in_valid delayed by 3. When out_valid=0, outputs hold their previous values.
- mode is sampled per sample at stage 1 and carried down the pipeline. A mode change mid-stream takes effect cleanly on the next sample, with no flush and no glitch.
- Mode 0:
  - Delayed bit 0 -> output = +LO.
  - Delayed bit 1 -> output = -LO.
- Mode 1:
  - Product p = rf * LO, full width RF_WIDTH+LO_WIDTH.
  - Output = (p + 2^(RF_WIDTH-2)) >>> (RF_WIDTH-1): round-half-up, arithmetic shift.
  - Result is saturated to the LO_WIDTH signed range. Saturation is always on in mode 1.
- Saturation event:
  - Any sample where either I or Q clipped (mode 1, or mode 0 with MIXER_NEG_SAT_EN) increments sat_count once per sample, on the out_valid cycle.
  - sat_count sticks at all-ones.
- sat_clear:
  - Zeros sat_count on the next clock.
  - If a saturation event occurs in the same cycle, clear wins and the count becomes 0.
- rf_out: rf_bit registered one clock, regardless of mode.
- Reset mid-stream: in-flight samples are discarded; out_valid is 0 until 3 clocks after the next in_valid.

Optional Feature:
- Macro: MIXER_NEG_SAT_EN.
- Defined: in mode 0, negating the most negative LO (-2^(LO_WIDTH-1)) yields +2^(LO_WIDTH-1)-1 and counts as a saturation event.
- Undefined: negation wraps two's-complement (-2048 stays -2048 for LO_WIDTH=12) and mode 0 never increments sat_count.
- Mode 1 is unaffected either way.

Test Plan:
- Reset, then mode=0, rf_bit held 0, in_valid=1, sine=100, cos=-300 -> after RF_DELAY+3 clocks, sinewave_out=100, cosinewave_out=-300, out_valid=1; rf_out follows rf_bit one clock late; outputs 0 and out_valid 0 during reset.
- mode=0, rf_bit toggling 0/1 each clock, sine=500 -> outputs alternate +500/-500, shifted by exactly RF_DELAY clocks relative to rf_bit.
- mode=1, RF_WIDTH=8, rf_sample=64, sine=1000 -> 64000+64=64064, >>>7 = 500; rf=-128, LO=-2048 -> 2047 and sat_count increments by 1.
- mode=0, sine=-2048, rf_bit=1 -> output 2047 and sat_count+1 with MIXER_NEG_SAT_EN; output -2048 and sat_count unchanged without it.
- in_valid pattern 1,0,1,1 -> out_valid pattern 1,0,1,1 exactly 3 clocks later; outputs hold during the gap. Asserting sat_clear in the same cycle as a saturation event -> sat_count=0.
- Reset asserted while 2 samples are in flight -> out_valid stays 0 until 3 clocks after the next in_valid; outputs read 0 immediately on assertion.
